// File: rtl/alu_exec_unit_pkg.sv
// ============================================================================
// Module  : alu_exec_unit_pkg
// Brief   : ALU select codes, default width and FSM encodings for the EX stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_exec_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Shared with the ALU control decoder; unknown codes execute as ADD.
    localparam logic [3:0] ALU_SEL_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SEL_SUB     = 4'b0001;
    localparam logic [3:0] ALU_SEL_ADD_ALT = 4'b0010;
    localparam logic [3:0] ALU_SEL_OR      = 4'b0100;
    localparam logic [3:0] ALU_SEL_AND     = 4'b0101;
    localparam logic [3:0] ALU_SEL_SUB_ALT = 4'b0110;
    localparam logic [3:0] ALU_SEL_XOR     = 4'b0111;
    localparam logic [3:0] ALU_SEL_SLL     = 4'b1000;
    localparam logic [3:0] ALU_SEL_SRL     = 4'b1001;
    localparam logic [3:0] ALU_SEL_SRA     = 4'b1010;
    localparam logic [3:0] ALU_SEL_SLT     = 4'b1101;
    localparam logic [3:0] ALU_SEL_SLTU    = 4'b1111;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    function automatic logic is_shift_sel(input logic [3:0] sel);
        return (sel == ALU_SEL_SLL) || (sel == ALU_SEL_SRL) || (sel == ALU_SEL_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_serial_shifter.sv
// ============================================================================
// Module  : alu_serial_shifter
// Brief   : 1-bit-per-step shifter; load captures data/amount/mode, step shifts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [XLEN-1:0]    i_data,
    input  logic [SHAMT_W-1:0] i_amt,
    input  logic               i_right,
    input  logic               i_arith,
    output logic [XLEN-1:0]    o_next,
    output logic               o_last
);

    logic [XLEN-1:0]    r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_right;
    logic               r_arith;

    // o_next is the accumulator after one more step; the top captures it on the last step.
    assign o_next = r_right ? {r_arith & r_acc[XLEN-1], r_acc[XLEN-1:1]}
                            : {r_acc[XLEN-2:0], 1'b0};
    assign o_last = (r_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_right <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_load) begin
            r_acc   <= i_data;
            r_cnt   <= i_amt;
            r_right <= i_right;
            r_arith <= i_arith;
        end else if (i_step && (r_cnt != '0)) begin
            r_acc <= o_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module  : alu_exec_unit
// Brief   : Execute-stage ALU with registered result/flags and valid/ready on
//           both sides. Define ALU_FAST_SHIFT_EN for a 1-cycle barrel shifter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            carry_flag,
    output logic            overflow_flag,
    output logic            sign_flag,
    output logic            busy
);

    logic               r_state;
    logic               w_state_next;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;
    logic               r_sign;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_start_serial;
    logic               w_shift_last;
    logic               w_shift_done;
    logic [XLEN-1:0]    w_shift_next;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;

    logic [XLEN:0]      w_add_sum;
    logic [XLEN:0]      w_sub_sum;
    logic               w_b_neg_sign;
    logic [XLEN-1:0]    w_res;
    logic               w_carry;
    logic               w_ovf;

    assign w_shamt    = op_b[SHAMT_W-1:0];
    assign w_is_shift = is_shift_sel(alu_sel);
    assign w_accept   = in_valid & in_ready;

    assign w_add_sum = {1'b0, op_a} + {1'b0, op_b};
    assign w_sub_sum = {1'b0, op_a} + {1'b0, ~op_b} + {{XLEN{1'b0}}, 1'b1};
    // Sign of (~op_b + 1): equals op_b's sign when the low bits are zero (0 and MIN negate to themselves).
    assign w_b_neg_sign = (op_b[XLEN-2:0] == '0) ? op_b[XLEN-1] : ~op_b[XLEN-1];

    always_comb begin
        w_res   = w_add_sum[XLEN-1:0];
        w_carry = w_add_sum[XLEN];
        w_ovf   = (op_a[XLEN-1] == op_b[XLEN-1]) & (w_add_sum[XLEN-1] != op_a[XLEN-1]);
        case (alu_sel)
            ALU_SEL_ADD, ALU_SEL_ADD_ALT: begin
                w_res = w_add_sum[XLEN-1:0];
            end
            ALU_SEL_SUB, ALU_SEL_SUB_ALT: begin
                w_res   = w_sub_sum[XLEN-1:0];
                w_carry = w_sub_sum[XLEN];
                w_ovf   = (op_a[XLEN-1] == w_b_neg_sign) & (w_sub_sum[XLEN-1] != op_a[XLEN-1]);
            end
            ALU_SEL_OR: begin
                w_res   = op_a | op_b;
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
            ALU_SEL_AND: begin
                w_res   = op_a & op_b;
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
            ALU_SEL_XOR: begin
                w_res   = op_a ^ op_b;
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
            ALU_SEL_SLL, ALU_SEL_SRL, ALU_SEL_SRA: begin
`ifdef ALU_FAST_SHIFT_EN
                if (alu_sel == ALU_SEL_SLL) begin
                    w_res = op_a << w_shamt;
                end else if (alu_sel == ALU_SEL_SRL) begin
                    w_res = op_a >> w_shamt;
                end else begin
                    w_res = $signed(op_a) >>> w_shamt;
                end
`else
                // Only shamt==0 takes this 1-cycle path; other amounts go serial.
                w_res = op_a;
`endif
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
            ALU_SEL_SLT: begin
                w_res   = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
            ALU_SEL_SLTU: begin
                w_res   = {{(XLEN-1){1'b0}}, (op_a < op_b)};
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign w_start_serial = 1'b0;
    assign w_shift_last   = 1'b0;
    assign w_shift_next   = '0;
`else
    assign w_start_serial = w_is_shift & (w_shamt != '0);

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (flush),
        .i_load  (w_accept & w_start_serial),
        .i_step  (r_state == ST_SHIFT),
        .i_data  (op_a),
        .i_amt   (w_shamt),
        .i_right (alu_sel != ALU_SEL_SLL),
        .i_arith (alu_sel == ALU_SEL_SRA),
        .o_next  (w_shift_next),
        .o_last  (w_shift_last)
    );
`endif

    assign w_shift_done = (r_state == ST_SHIFT) & w_shift_last;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && w_start_serial) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_shift_last)              w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = rst_n & ~flush & (r_state == ST_IDLE) & (~r_out_valid | out_ready);
`ifdef ALU_FAST_SHIFT_EN
        busy     = 1'b0;
`else
        busy     = (r_state == ST_SHIFT);
`endif
    end

    // Result and flags; a simultaneous accept and consume overwrites without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_start_serial) begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
            r_sign      <= w_res[XLEN-1];
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end else if (w_shift_done) begin
            r_result    <= w_shift_next;
            r_zero      <= (w_shift_next == '0);
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_sign      <= w_shift_next[XLEN-1];
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign zero_flag     = r_zero;
    assign carry_flag    = r_carry;
    assign overflow_flag = r_ovf;
    assign sign_flag     = r_sign;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module  : tb_alu_exec_unit
// Brief   : Self-checking bench for alu_exec_unit: directed cases plus random
//           traffic against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a, op_b;
    logic        in_ready, out_valid, zero_flag, carry_flag, overflow_flag, sign_flag, busy;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .overflow_flag(overflow_flag), .sign_flag(sign_flag),
        .busy(busy)
    );

    // Reference model state: the visible output and a pending serial shift.
    logic        m_valid = 1'b0;
    logic [31:0] m_res   = '0;
    logic        m_z = 1'b0, m_c = 1'b0, m_v = 1'b0, m_s = 1'b0;
    int          m_count = 0;
    logic [31:0] m_pend  = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void ref_alu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic v,
                                    output int cycles);
        logic [32:0] s;
        logic [31:0] nb;
        int sh;
        sh = int'(b % 32);
        c = 1'b0; v = 1'b0; cycles = 0;
        case (sel)
            4'h1, 4'h6: begin
                r  = a - b;
                c  = (a >= b);
                nb = 32'd0 - b;
                v  = (a[31] == nb[31]) && (r[31] != a[31]);
            end
            4'h4: r = a | b;
            4'h5: r = a & b;
            4'h7: r = a ^ b;
            4'h8: begin r = a << sh; cycles = sh; end
            4'h9: begin r = a >> sh; cycles = sh; end
            4'hA: begin r = $signed(a) >>> sh; cycles = sh; end
            4'hD: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hF: r = (a < b) ? 32'd1 : 32'd0;
            default: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
        endcase
`ifdef ALU_FAST_SHIFT_EN
        cycles = 0;
`endif
    endfunction

    function automatic logic exp_in_ready();
        return rst_n && !flush && (m_count == 0) && (!m_valid || out_ready);
    endfunction

    // Compare process: at each negedge check outputs, then advance the model
    // with the inputs that the next rising edge will sample.
    initial begin
        logic [31:0] r;
        logic        c, v;
        int          n;
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, exp_in_ready());
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_count > 0);
            if (m_valid) begin
                chk("result", result, m_res);
                chk("flags_zcvs", {zero_flag, carry_flag, overflow_flag, sign_flag},
                    {m_z, m_c, m_v, m_s});
            end
            if (!rst_n) begin
                m_valid = 0; m_res = '0; m_z = 0; m_c = 0; m_v = 0; m_s = 0; m_count = 0;
            end else if (flush) begin
                m_valid = 0; m_count = 0;
            end else if (in_valid && exp_in_ready()) begin
                ref_alu(alu_sel, op_a, op_b, r, c, v, n);
                if (n > 0) begin
                    m_count = n; m_pend = r; m_valid = 0;
                end else begin
                    m_valid = 1; m_res = r; m_c = c; m_v = v; m_z = (r == 0); m_s = r[31];
                end
            end else if (m_count > 0) begin
                m_count--;
                if (m_count == 0) begin
                    m_valid = 1; m_res = m_pend; m_c = 0; m_v = 0;
                    m_z = (m_pend == 0); m_s = m_pend[31];
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        alu_sel = sel; op_a = a; op_b = b; in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) break;
            tick();
            if (k == 63) begin
                tests++; fails++;
                $display("FAIL issue_timeout: in_ready stayed 0, required 1");
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges, output int nbusy);
        edges = 0; nbusy = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (out_valid) return;
            if (busy) nbusy++;
            tick();
            edges++;
        end
        tests++; fails++;
        $display("FAIL wait_out_timeout: out_valid stayed 0, required 1");
    endtask

    initial begin
        int edges, nb, seen;
        int exp_edges, exp_busy;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; alu_sel = 4'h0;
        op_a = 32'd1; op_b = 32'd2; out_ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_result", result, 0);
        end
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        // ADD then SUB back-to-back
        tick();
        alu_sel = 4'b0000; op_a = 32'h7FFF_FFFF; op_b = 32'h1; in_valid = 1'b1;
        @(negedge clk);
        tick();
        alu_sel = 4'b0001; op_a = 32'd5; op_b = 32'd5;
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_ovf_sign_carry", {overflow_flag, sign_flag, carry_flag}, 3'b110);
        chk("add_no_bubble_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("sub_valid", out_valid, 1);
        chk("sub_result", result, 0);
        chk("sub_zero_carry", {zero_flag, carry_flag}, 2'b11);
        tick();

`ifdef ALU_FAST_SHIFT_EN
        exp_edges = 0; exp_busy = 0;
`else
        exp_edges = 4; exp_busy = 4;
`endif
        issue(4'b1010, 32'h8000_0010, 32'd4);
        wait_out(edges, nb);
        chk("sra_result", result, 32'hF800_0001);
        chk("sra_latency", edges, exp_edges);
        chk("sra_busy_cycles", nb, exp_busy);
        tick();
        issue(4'b1010, 32'h8000_0010, 32'd0);
        wait_out(edges, nb);
        chk("sra0_latency", edges, 0);
        chk("sra0_result", result, 32'h8000_0010);
        tick();

        // Backpressure on SLTU
        out_ready = 1'b0;
        issue(4'b1111, 32'd1, 32'hFFFF_FFFF);
        wait_out(edges, nb);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 1);
            chk("bp_in_ready", in_ready, 0);
            tick();
            @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        tick();
        @(negedge clk);
        chk("bp_single_transfer", out_valid, 0);
        tick();

        // Flush in the middle of a 20-step SLL
        issue(4'b1000, 32'h0000_0003, 32'd20);
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
            tick();
        end
`ifndef ALU_FAST_SHIFT_EN
        chk("flush_no_output", seen, 0);
        chk("flush_idle", busy, 0);
`endif
        issue(4'b0000, 32'd2, 32'd3);
        wait_out(edges, nb);
        chk("post_flush_add", result, 32'd5);
        tick();

        issue(4'b0011, 32'd4, 32'd9);
        wait_out(edges, nb);
        chk("undef_code_result", result, 32'd13);
        chk("undef_code_carry", carry_flag, 0);
        tick();

        // Random traffic, checked cycle by cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pick [5];
            pick[0] = $urandom(); pick[1] = 32'h0; pick[2] = 32'h8000_0000;
            pick[3] = 32'h7FFF_FFFF; pick[4] = 32'hFFFF_FFFF;
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_sel   = 4'($urandom_range(0, 15));
            op_a      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(1, 4)] : pick[0];
            op_b      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(1, 4)] : $urandom();
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU datapath. It consumes the 4-bit ALU select code from the ALU control decoder plus two XLEN operands, and produces a registered result and branch flags.
- Add, sub, logic and set-less-than complete in 1 cycle.
- Shifts run on an iterative 1-bit-per-cycle serial shifter to save area.
- Valid/ready handshakes sit on both sides so the hazard/stall logic can back-pressure it.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- flush  input  1  drop in-flight shift and any unconsumed result
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation this cycle
- alu_sel  input  4  operation code (encoding below)
- op_a  input  XLEN  operand A / shift source
- op_b  input  XLEN  operand B; op_b[SHAMT_W-1:0] is the shift amount
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- zero_flag  output  1  result == 0
- carry_flag  output  1  add carry-out; for sub, 1 = no borrow (A >= B unsigned)
- overflow_flag  output  1  signed overflow of add/sub
- sign_flag  output  1  result[XLEN-1]
- busy  output  1  high in SHIFT state

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Codes: 0000/0010 ADD; 0001/0110 SUB; 0100 OR; 0101 AND; 0111 XOR; 1000 SLL; 1001 SRL; 1010 SRA; 1101 SLT; 1111 SLTU. Any other code executes as ADD.
- Reset (rst_n=0 at clk edge):
  - state=IDLE; result, all flags, out_valid, busy = 0.
  - in_ready is forced 0 while rst_n=0.
  - A shift in progress is aborted and produces no output.
- States are IDLE and SHIFT.
- in_ready = rst_n & (state==IDLE) & (!out_valid | out_ready).
- Accept occurs when in_valid & in_ready.
- Non-shift accept:
  - Result and flags are registered in the same edge; out_valid=1 next cycle (latency 1).
  - Back-to-back accepts give throughput of 1 per cycle.
- Shift accept with shamt==0: handled as a 1-cycle op; result = op_a.
- Shift accept with shamt=N>0:
  - Load acc=op_a and cnt=N; go to SHIFT.
  - Each SHIFT cycle: shift acc by 1 (SRA replicates the MSB); cnt--.
  - On the cycle cnt reaches 0: result=acc, out_valid=1, return to IDLE.
  - out_valid rises exactly N cycles after the accept edge.
- Output hold: while out_valid & !out_ready, result and flags are held stable and in_ready=0.
- Hand-off: out_valid drops the cycle after out_ready, unless a new op is accepted in that same cycle.
- Arithmetic:
  - Add/sub use an (XLEN+1)-bit sum.
  - overflow = (a_sign==b'_sign) & (sum_sign!=a_sign), where b' is op_b for add and ~op_b+1 for sub.
  - SLT/SLTU result = {XLEN-1 zeros, lt}.
  - carry_flag and overflow_flag are 0 for all non-add/sub ops.
  - zero_flag and sign_flag are computed from the final result for all ops.
- flush (sampled at the clock edge, priority below reset, above everything else):
  - state=IDLE, out_valid=0, cnt=0.
  - in_ready=0 in the flush cycle.
- Simultaneous accept and out_ready in IDLE: the old result is consumed and the new one loaded in the same edge; no bubble.

Optional Feature:
- ALU_FAST_SHIFT_EN defined: shifts use a combinational barrel shifter and complete in 1 cycle like other ops. SHIFT state and busy are unused (busy tied 0).
- ALU_FAST_SHIFT_EN undefined: serial shifter as above.

Decomposition:
- Shared package/defines file holds:
  - the ALU_SEL_* code constants, shared with the ALU control decoder;
  - XLEN_DEFAULT;
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
- One sub-module, alu_serial_shifter: acc/cnt registers, load/step/done interface, direction and arithmetic-mode inputs. It is instantiated only when ALU_FAST_SHIFT_EN is undefined.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, result=0. After release, in_ready=1.
- ADD then SUB back-to-back:
  - ADD 0x7FFFFFFF+0x1 -> result 0x80000000, overflow=1, sign=1, carry=0.
  - SUB 5-5 -> result 0, zero=1, carry=1.
  - Each with latency 1, no bubble.
- SRA 0x80000010 by 4 (serial build):
  - busy for 4 cycles; out_valid 4 cycles after accept.
  - result 0xF8000001.
  - shamt=0 variant returns op_a in 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after SLTU 1<0xFFFFFFFF -> result=1 held stable, in_ready=0. Releasing gives one transfer.
- Flush mid-shift: SLL by 20, assert flush on cycle 7 -> no out_valid, state IDLE. The next op is ADD 2+3 -> result 5.
- Undefined code 0011 with 4,9 -> result 13 (ADD behaviour, carry=0).
